oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
- Sequences OAM DMA (FF46) transfers into the sprite OAM RAM: 160 bytes from {page, 8'h00} to OAM 0x00-0x9F, one byte per CPU M-cycle.
- Sits between the CPU register bus, the system memory bus and the OAM port of the sprite unit.
- Drives the sprite unit's DMA-side inputs: dma_active, oam_wr, oam_addr_in, oam_di.
- While a transfer runs, CPU OAM accesses are locked out and OAM reads return 0xFF.

Parameters:
- OAM_BYTES, 160, number of bytes per transfer; index width fixed at 8.
- START_DELAY, 1, M-cycles between the FF46 write and the first byte transfer.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ce_cpu  in  1  one-clk strobe per CPU M-cycle; all state advances only on clk edges with ce_cpu=1.
- isGBC  in  1  selects CGB source-page mapping.
- cpu_sel  in  1  FF46 addressed.
- cpu_wr  in  1  CPU write strobe.
- cpu_di  in  8  CPU write data.
- cpu_do  out  8  FF46 readback: last written value.
- dma_rd  out  1  bus read request, high in XFER.
- dma_addr  out  16  bus read address {src_page_mapped, idx}.
- dma_di  in  8  bus read data, valid in the same M-cycle as dma_addr.
- dma_active  out  1  transfer in progress; connects to the sprite unit's dma_active.
- oam_wr  out  1  OAM write enable; the sprite unit gates it with ce_cpu.
- oam_addr  out  8  OAM byte index.
- oam_di  out  8  OAM write data, equal to dma_di.

Behaviour:
- Reset values (synchronous reset wins over everything):
  - state=IDLE, idx=0, ff46=8'h00, delay counter=0, pending=0.
  - dma_active=0, oam_wr=0, dma_rd=0, oam_addr=0, cpu_do=8'h00.
- FF46 write: cpu_sel & cpu_wr & ce_cpu.
  - Latch ff46 <= cpu_di and src_page <= cpu_di.
  - Load the delay counter with START_DELAY; set pending=1.
- States:
  - IDLE: on FF46 write -> START.
  - START: on each ce_cpu the counter decrements; when it reaches 0 -> XFER with idx=0, pending=0.
  - XFER: each ce_cpu edge writes one byte:
    - oam_addr=idx, oam_di=dma_di, dma_addr={mapped page, idx}.
    - Then idx<=idx+1.
    - The ce_cpu edge with idx=OAM_BYTES-1 performs the last write, then -> IDLE and idx<=0.
- Outputs by state:
  - dma_active=1 in XFER only, not in START; it drops the clk after the final write.
  - oam_wr=dma_rd=1 in XFER only.
  - oam_addr=0 outside XFER.
- Latency:
  - FF46 write at M-cycle N -> first OAM write (addr 0x00) at M-cycle N+1+START_DELAY.
  - Last write (0x9F) at M-cycle N+START_DELAY+OAM_BYTES.
- Restart while in XFER:
  - The current transfer continues with the old page for START_DELAY more M-cycles and dma_active stays 1.
  - Then idx<=0 with the new page. No gap in dma_active.
- Write during START: the page is replaced and the delay counter reloads; the first write slips accordingly.
- Write coinciding with the final byte: the final byte is written, and the state goes to START, not IDLE. dma_active drops for the delay M-cycles.
- Source mapping (applied combinationally to dma_addr[15:8]):
  - DMG: page>=8'hE0 maps to page-8'h20, i.e. FE->DE, FF->DF.
  - CGB: page>=8'hE0 maps to page-8'h20 as well.
  - Pages 00-DF pass unchanged on both.
- ce_cpu low: no state change, all outputs hold.
- Reset mid-transfer: IDLE next clk, dma_active=0, OAM contents are left partially written.
- cpu_do returns ff46 at all times, including during a transfer.

Decomposition:
- Shared gb package holds:
  - FF46 register address constant.
  - OAM_BYTES constant.
  - State enum {IDLE, START, XFER}.
- Source-page mapping as a small sub-module, oam_dma_src_map (page, isGBC -> mapped page). Everything else stays in one module.

Test Plan:
- Write FF46=8'hC1 at M-cycle 10 -> dma_active rises after M-cycle 11; writes at M-cycles 12..171, addr 0x00..0x9F from 0xC100..0xC19F; dma_active=0 after M-cycle 171; OAM[i]=mem[0xC100+i].
- Write 8'hFE with isGBC=0 -> dma_addr runs 0xDE00..0xDE9F; write 8'h80 -> 0x8000..0x809F unmapped.
- Rewrite FF46=8'hD0 when idx=50 -> byte 51 still comes from old page, next write is addr 0x00 from 0xD000, dma_active never drops, 160 writes after restart.
- Assert reset at idx=20 -> next clk dma_active=0, oam_wr=0, cpu_do=0x00; OAM bytes 20..159 unchanged.
- Hold ce_cpu low 5 clk mid-XFER -> idx, oam_addr and dma_addr stable, no extra writes; exactly 160 oam_wr&ce_cpu pulses total.
- Read FF46 after writing 0x3A during XFER -> cpu_do=0x3A.

Source files
------------

// File: rtl/oam_dma_ctrl_pkg.sv
// Shared definitions for the OAM DMA (FF46) sequencer: register address,
// transfer length and sequencer state encodings.
package oam_dma_ctrl_pkg;

    localparam logic [15:0] FF46_ADDR     = 16'hFF46;
    localparam int          DMA_OAM_BYTES = 160;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;

    // Pages E0-FF alias the echo region; the DMA engine reads work RAM instead.
    function automatic logic page_is_echo(input logic [7:0] page);
        return (page >= 8'hE0);
    endfunction

endpackage

// File: rtl/oam_dma_src_map.sv
// Maps the FF46 source page to the page actually driven onto the system bus.
module oam_dma_src_map
    import oam_dma_ctrl_pkg::*;
(
    input  logic [7:0] page,
    input  logic       isGBC,
    output logic [7:0] mapped
);

    // Echo-region pages fold down by 0x20 on both DMG and CGB.
    always_comb begin
        mapped = page;
        case (isGBC)
            1'b0: begin
                if (page_is_echo(page)) begin
                    mapped = page - 8'h20;
                end else begin
                    mapped = page;
                end
            end
            1'b1: begin
                if (page_is_echo(page)) begin
                    mapped = page - 8'h20;
                end else begin
                    mapped = page;
                end
            end
            default: mapped = page;
        endcase
    end

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: copies OAM_BYTES bytes from {page, 8'h00} into sprite
// OAM, one byte per CPU M-cycle, after a START_DELAY M-cycle start latency.
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
#(
    parameter int OAM_BYTES   = DMA_OAM_BYTES,
    parameter int START_DELAY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_cpu,
    input  logic        isGBC,
    input  logic        cpu_sel,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_di,
    output logic [7:0]  cpu_do,
    output logic        dma_rd,
    output logic [15:0] dma_addr,
    input  logic [7:0]  dma_di,
    output logic        dma_active,
    output logic        oam_wr,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_di
);

    localparam logic [7:0] START_LOAD = 8'(START_DELAY);
    localparam logic [7:0] LAST_IDX   = 8'(OAM_BYTES - 1);

    logic [1:0] state_r;
    logic [7:0] idx_r;
    logic [7:0] ff46_r;
    logic [7:0] src_page_r;
    logic [7:0] xfer_page_r;
    logic [7:0] delay_r;
    logic       pending_r;

    logic       ff46_wr_s;
    logic       last_s;
    logic       restart_due_s;
    logic       in_xfer_s;
    logic [7:0] mapped_page_s;

    assign ff46_wr_s     = cpu_sel & cpu_wr;
    assign last_s        = (idx_r == LAST_IDX);
    assign restart_due_s = pending_r & (delay_r <= 8'd1);
    assign in_xfer_s     = (state_r == ST_XFER);

    // xfer_page_r keeps the running page so a restart only switches at idx 0.
    oam_dma_src_map u_src_map (
        .page   (xfer_page_r),
        .isGBC  (isGBC),
        .mapped (mapped_page_s)
    );

    // Sequencer: FF46 latch, start countdown and byte stepping, gated by ce_cpu.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            idx_r       <= 8'd0;
            ff46_r      <= 8'h00;
            src_page_r  <= 8'h00;
            xfer_page_r <= 8'h00;
            delay_r     <= 8'd0;
            pending_r   <= 1'b0;
        end else if (ce_cpu) begin
            if (ff46_wr_s) begin
                ff46_r     <= cpu_di;
                src_page_r <= cpu_di;
                delay_r    <= START_LOAD;
                pending_r  <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (ff46_wr_s) begin
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (!ff46_wr_s) begin
                        if (delay_r <= 8'd1) begin
                            state_r     <= ST_XFER;
                            idx_r       <= 8'd0;
                            xfer_page_r <= src_page_r;
                            pending_r   <= 1'b0;
                            delay_r     <= 8'd0;
                        end else begin
                            delay_r <= delay_r - 8'd1;
                        end
                    end
                end
                ST_XFER: begin
                    if (ff46_wr_s) begin
                        // A write on the final byte must not fall back to IDLE.
                        if (last_s) begin
                            state_r <= ST_START;
                            idx_r   <= 8'd0;
                        end else begin
                            idx_r <= idx_r + 8'd1;
                        end
                    end else if (restart_due_s) begin
                        idx_r       <= 8'd0;
                        xfer_page_r <= src_page_r;
                        pending_r   <= 1'b0;
                        delay_r     <= 8'd0;
                    end else begin
                        if (pending_r) begin
                            delay_r <= delay_r - 8'd1;
                        end
                        if (last_s) begin
                            idx_r   <= 8'd0;
                            state_r <= pending_r ? ST_START : ST_IDLE;
                        end else begin
                            idx_r <= idx_r + 8'd1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    idx_r   <= 8'd0;
                end
            endcase
        end
    end

    // Output decode from registered state; strobes are suppressed during reset
    // so the edge that resets a transfer does not also write OAM.
    always_comb begin
        dma_active = in_xfer_s;
        if (in_xfer_s && !reset) begin
            oam_wr = 1'b1;
            dma_rd = 1'b1;
        end else begin
            oam_wr = 1'b0;
            dma_rd = 1'b0;
        end
        if (in_xfer_s) begin
            oam_addr = idx_r;
        end else begin
            oam_addr = 8'h00;
        end
    end

    assign dma_addr = {mapped_page_s, idx_r};
    assign oam_di   = dma_di;
    assign cpu_do   = ff46_r;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: table-driven full transfers plus
// hand-written restart, start-rewrite, final-byte, ce-stall and reset sequences.
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce_cpu;
    logic        isGBC;
    logic        cpu_sel;
    logic        cpu_wr;
    logic [7:0]  cpu_di;
    logic [7:0]  cpu_do;
    logic        dma_rd;
    logic [15:0] dma_addr;
    logic [7:0]  dma_di;
    logic        dma_active;
    logic        oam_wr;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_di;

    oam_dma_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .ce_cpu     (ce_cpu),
        .isGBC      (isGBC),
        .cpu_sel    (cpu_sel),
        .cpu_wr     (cpu_wr),
        .cpu_di     (cpu_di),
        .cpu_do     (cpu_do),
        .dma_rd     (dma_rd),
        .dma_addr   (dma_addr),
        .dma_di     (dma_di),
        .dma_active (dma_active),
        .oam_wr     (oam_wr),
        .oam_addr   (oam_addr),
        .oam_di     (oam_di)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ (a[15:8] + 8'h37);
    endfunction

    assign dma_di = mem_byte(dma_addr);

    int checks = 0;
    int errors = 0;

    int edge_no = 0;
    int wr_count = 0;
    int bad_beats = 0;
    int ff46_edge = 0;
    logic [15:0] log_addr [0:4095];
    int          log_edge [0:4095];
    logic [7:0]  oam_m    [0:159];

    // Shadow of the sprite unit: records every ce-qualified OAM write.
    always @(negedge clk) begin
        if (ce_cpu) begin
            edge_no <= edge_no + 1;
            if (cpu_sel && cpu_wr) ff46_edge <= edge_no + 1;
            if (oam_wr) begin
                if (oam_addr < 8'd160) oam_m[oam_addr] <= oam_di;
                log_addr[wr_count % 4096] <= dma_addr;
                log_edge[wr_count % 4096] <= edge_no + 1;
                wr_count <= wr_count + 1;
                if (oam_di !== mem_byte(dma_addr) || oam_addr !== dma_addr[7:0])
                    bad_beats <= bad_beats + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ff46_write(input logic [7:0] v);
        cpu_sel = 1'b1;
        cpu_wr  = 1'b1;
        cpu_di  = v;
        step();
        cpu_sel = 1'b0;
        cpu_wr  = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k = 0;
        while (wr_count < n && k < budget) begin
            step();
            k++;
        end
        if (wr_count < n) check("wait_writes_timeout", wr_count, n);
    endtask

    task automatic wait_idle(input int n, input int budget);
        int k = 0;
        while (!(wr_count >= n && !dma_active) && k < budget) begin
            step();
            k++;
        end
        if (k >= budget) check("wait_idle_timeout", wr_count, n);
    endtask

    task automatic check_oam(input string name, input int lo, input int hi, input logic [7:0] page);
        int bad = 0;
        for (int i = lo; i <= hi; i++) begin
            if (oam_m[i] !== mem_byte({page, 8'(i)})) bad++;
        end
        check(name, bad, 0);
    endtask

    typedef struct {
        logic [7:0]  page;
        logic        gbc;
        logic [15:0] first;
        logic [15:0] last;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int base;
        int gaps;
        int unstable;
        logic [7:0]  hold_a;
        logic [15:0] hold_d;

        vecs[0] = '{8'hC1, 1'b0, 16'hC100, 16'hC19F};
        vecs[1] = '{8'hFE, 1'b0, 16'hDE00, 16'hDE9F};
        vecs[2] = '{8'h80, 1'b0, 16'h8000, 16'h809F};
        vecs[3] = '{8'hFF, 1'b1, 16'hDF00, 16'hDF9F};
        vecs[4] = '{8'hDF, 1'b0, 16'hDF00, 16'hDF9F};
        vecs[5] = '{8'hE0, 1'b1, 16'hC000, 16'hC09F};

        reset = 1'b1; ce_cpu = 1'b1; isGBC = 1'b0;
        cpu_sel = 1'b0; cpu_wr = 1'b0; cpu_di = 8'h00;
        repeat (3) step();
        check("reset_outputs", {dma_active, oam_wr, dma_rd, oam_addr, cpu_do}, 32'h0);
        reset = 1'b0;
        step();
        check("idle_outputs", {dma_active, oam_wr, dma_rd, oam_addr, cpu_do}, 32'h0);

        // Table-driven full transfers: mapping, latency, content.
        for (int v = 0; v < 6; v++) begin
            base  = wr_count;
            isGBC = vecs[v].gbc;
            ff46_write(vecs[v].page);
            check("active_low_in_start", dma_active, 1'b0);
            step();
            check("active_high_in_xfer", dma_active, 1'b1);
            wait_idle(base + 160, 400);
            check("xfer_count", wr_count - base, 160);
            check("first_dma_addr", log_addr[base], vecs[v].first);
            check("last_dma_addr", log_addr[base + 159], vecs[v].last);
            check("first_latency", log_edge[base] - ff46_edge, 2);
            check("last_latency", log_edge[base + 159] - ff46_edge, 161);
            check("cpu_do_readback", cpu_do, vecs[v].page);
            check("idle_after_xfer", {dma_active, oam_wr, dma_rd, oam_addr}, 32'h0);
            check_oam("oam_content", 0, 159, vecs[v].first[15:8]);
        end
        isGBC = 1'b0;

        // Rewrite during START: new page, counter reload.
        base = wr_count;
        ff46_write(8'h30);
        ff46_write(8'h31);
        check("rewrite_start_active", dma_active, 1'b0);
        wait_idle(base + 160, 400);
        check("rewrite_start_count", wr_count - base, 160);
        check("rewrite_start_first", log_addr[base], 16'h3100);
        check("rewrite_start_latency", log_edge[base] - ff46_edge, 2);

        // Restart at idx 50: one more old byte, then new page with no gap.
        base = wr_count;
        ff46_write(8'hC2);
        wait_writes(base + 50, 200);
        ff46_write(8'hD0);
        gaps = 0;
        for (int k = 0; k < 600 && !(wr_count >= base + 212 && !dma_active); k++) begin
            if (!dma_active) gaps++;
            step();
        end
        check("restart_count", wr_count - base, 212);
        check("restart_byte50", log_addr[base + 50], 16'hC232);
        check("restart_byte51_old", log_addr[base + 51], 16'hC233);
        check("restart_new_first", log_addr[base + 52], 16'hD000);
        check("restart_new_last", log_addr[base + 211], 16'hD09F);
        check("restart_no_gap", gaps, 0);
        check("restart_cpu_do", cpu_do, 8'hD0);

        // Write coinciding with the final byte: START, not IDLE.
        base = wr_count;
        ff46_write(8'h10);
        wait_writes(base + 159, 400);
        ff46_write(8'h20);
        check("final_coincide_start", dma_active, 1'b0);
        check("final_coincide_last_old", log_addr[base + 159], 16'h109F);
        step();
        check("final_coincide_resume", dma_active, 1'b1);
        wait_idle(base + 320, 400);
        check("final_coincide_count", wr_count - base, 320);
        check("final_coincide_new_first", log_addr[base + 160], 16'h2000);
        check("final_coincide_latency", log_edge[base + 160] - ff46_edge, 2);

        // ce_cpu held low mid-transfer.
        base = wr_count;
        ff46_write(8'h50);
        wait_writes(base + 30, 200);
        ce_cpu = 1'b0;
        hold_a = oam_addr;
        hold_d = dma_addr;
        unstable = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (oam_addr !== hold_a || dma_addr !== hold_d || !dma_active) unstable++;
        end
        check("ce_low_stable", unstable, 0);
        check("ce_low_no_writes", wr_count - base, 30);
        ce_cpu = 1'b1;
        wait_idle(base + 160, 400);
        check("ce_low_total", wr_count - base, 160);
        check("ce_low_resume_addr", log_addr[base + 30], 16'h501E);

        // FF46 readback while a transfer runs.
        base = wr_count;
        ff46_write(8'hC1);
        wait_writes(base + 5, 100);
        ff46_write(8'h3A);
        check("readback_3a", cpu_do, 8'h3A);
        wait_idle(base + 167, 400);
        check("readback_count", wr_count - base, 167);
        check("readback_new_first", log_addr[base + 7], 16'h3A00);
        check_oam("readback_oam", 0, 159, 8'h3A);

        // Reset at idx 20 leaves OAM partially written.
        base = wr_count;
        ff46_write(8'h40);
        wait_writes(base + 20, 100);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset_outputs", {dma_active, oam_wr, dma_rd, oam_addr, cpu_do}, 32'h0);
        repeat (3) step();
        check("midreset_writes", wr_count - base, 20);
        check("midreset_still_idle", dma_active, 1'b0);
        check_oam("midreset_oam_new", 0, 19, 8'h40);
        check_oam("midreset_oam_old", 20, 159, 8'h3A);

        check("beat_data_addr", bad_beats, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
